// File: rtl/hpi_pkg.sv
// rtl/hpi_pkg.sv - shared FSM state type and HPI register-select constants
package hpi_pkg;

    // Bus cycle phases of one HPI transaction.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } hpi_state_e;

    // HPI register selects driven on hpi_addr.
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_rr_arb2.sv
// rtl/hpi_rr_arb2.sv - two-way round-robin grant selection
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[1:0]    : request lines, bit N = requester N
//   take        : the FSM accepts the offered grant on this edge
//   gnt_valid   : at least one request is pending
//   gnt_idx     : index of the requester that would be granted
module hpi_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Index of the requester that wins a tie; reset gives m0 the tie.
    logic prio_q, prio_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req[0] && req[1]) ? prio_q : req[1];
        prio_d    = prio_q;
        // The winner of an accepted grant loses the next tie.
        if (take && gnt_valid) begin
            prio_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// rtl/hpi_bus_arbiter.sv - two-requester arbiter and timing engine for an HPI bus
// Ports:
//   clk_clk, reset_reset_n            : clock, asynchronous active-low reset
//   mN_req/we/addr/wdata (N=0,1)      : request, direction, register select, write data
//   mN_ack, mN_rdata                  : completion pulse and read data to requester N
//   hpi_cs_n, hpi_rd_n, hpi_wr_n      : active-low HPI strobes
//   hpi_addr, hpi_dout, hpi_oe        : register select, write data and pad enable
//   hpi_din                           : read data from the pad
module hpi_bus_arbiter
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_dout,
    output logic        hpi_oe,
    input  logic [15:0] hpi_din
);

    // Counter reload values: a phase lasts (reload + 1) cycles.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    hpi_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;

    logic arb_valid, arb_idx, arb_take;

    hpi_rr_arb2 u_arb (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .req       ({m1_req, m0_req}),
        .take      (arb_take),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // Address and data stay on the latched values between transactions, so
    // the pad sees no change through HOLD and the following IDLE.
    assign hpi_addr = addr_q;
    assign hpi_dout = wdata_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        arb_take = 1'b0;
        hpi_cs_n = 1'b1;
        hpi_rd_n = 1'b1;
        hpi_wr_n = 1'b1;
        hpi_oe   = 1'b0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    arb_take = 1'b1;
                    gnt_d    = arb_idx;
                    we_d     = arb_idx ? m1_we    : m0_we;
                    addr_d   = arb_idx ? m1_addr  : m0_addr;
                    wdata_d  = arb_idx ? m1_wdata : m0_wdata;
                    cnt_d    = SETUP_LD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
                hpi_rd_n = we_q;
                hpi_wr_n = ~we_q;
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: the pad data is sampled on this edge.
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_d = hpi_din;
                        end else begin
                            rdata0_d = hpi_din;
                        end
                    end
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
                if (cnt_q == 4'd0) begin
                    m0_ack  = ~gnt_q;
                    m1_ack  = gnt_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 2'd0;
            wdata_q  <= 16'd0;
            rdata0_q <= 16'd0;
            rdata1_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: doc/hpi_bus_arbiter.md
HPI_BUS_ARBITER -- requirements
Module: hpi_bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles of cs/addr/data setup before the strobe, legal range 1..15.
REQ-002 SHALL have parameter STROBE_CYC, default 4: cycles rd_n/wr_n is held low, legal range 1..15.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles cs/addr/data are held after the strobe, legal range 1..15.
REQ-004 clk_clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_req  in  1  request from requester N (N=0,1); held high until mN_ack.
REQ-007 mN_we  in  1  1 = write, 0 = read; stable while mN_req is high.
REQ-008 mN_addr  in  2  HPI register select; stable while mN_req is high.
REQ-009 mN_wdata  in  16  write data; stable while mN_req is high.
REQ-010 mN_ack  out  1  one-cycle completion pulse to requester N.
REQ-011 mN_rdata  out  16  read data; valid with mN_ack; held until the next read by N completes.
REQ-012 hpi_cs_n, hpi_rd_n, hpi_wr_n  out  1 each  HPI strobes, active-low.
REQ-013 hpi_addr  out  2  HPI register address.
REQ-014 hpi_dout  out  16  write data to pad; hpi_oe  out  1  pad output enable.
REQ-015 hpi_din  in  16  read data from pad.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE and HOLD; a 4-bit down-counter SHALL time SETUP, STROBE and HOLD.
REQ-017 In IDLE, if any mN_req is high, the FSM SHALL grant one requester, latch its we/addr/wdata and enter SETUP on the same edge.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset, m0 has priority.
REQ-019 SETUP: cs_n=0, hpi_addr=latched addr, hpi_oe=we, hpi_dout=latched wdata for SETUP_CYC cycles, then enter STROBE.
REQ-020 STROBE: rd_n=0 (read) or wr_n=0 (write), other signals as in SETUP, for STROBE_CYC cycles, then enter HOLD.
REQ-021 Read data SHALL be registered from hpi_din at the edge that ends the last STROBE cycle.
REQ-022 HOLD: strobes high, cs_n/addr/oe/dout unchanged, for HOLD_CYC cycles; mN_ack SHALL be high in the final HOLD cycle only; the FSM then enters IDLE.
REQ-023 From the edge that samples req, ack SHALL be sampled high SETUP_CYC+STROBE_CYC+HOLD_CYC edges later (7 with defaults).
REQ-024 At least one IDLE cycle (cs_n=1, oe=0) SHALL separate consecutive transactions for bus turnaround.
REQ-025 A request that rises during a transaction SHALL wait; a request dropped before grant SHALL be ignored.
REQ-026 Only the granted requester's ack and rdata SHALL change; the other's rdata SHALL hold.
REQ-027 rd_n and wr_n SHALL never be low at the same time, nor low while cs_n=1.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE and these values: cs_n=1, rd_n=1, wr_n=1, oe=0, addr=0, dout=0, acks=0, rdata=0, counter=0, round-robin pointer to m0 priority; this SHALL apply mid-transaction, and the aborted transaction SHALL never be acked.

Structure
REQ-029 Package hpi_pkg SHALL hold the state enum and constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3.
REQ-030 Round-robin grant logic SHALL be one sub-module, hpi_rr_arb2; timing and the FSM stay in hpi_bus_arbiter.

Verification
REQ-031 m0 write addr=2 wdata=0x1234, defaults -> cs_n low 7 cycles, wr_n low cycles 2-5, oe high throughout, m0_ack pulses at edge 7.
REQ-032 m1 read addr=0, hpi_din=0xBEEF during STROBE -> m1_rdata=0xBEEF with m1_ack; m0_rdata unchanged.
REQ-033 m0 and m1 requests held high together for 4 transactions -> grants alternate m0,m1,m0,m1 with one IDLE cycle between each.
REQ-034 Reset pulse during STROBE -> all outputs reach reset values without a clock edge; no ack; the next request is granted to m0.
REQ-035 Parameters SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=1 on a read -> ack at edge 5; rdata captured at the edge ending STROBE.
REQ-036 Every scenario: assertion checks that rd_n and wr_n are never both low and no strobe is low while cs_n=1.
